// File: rtl/demux1x2_pkg.sv
// Shared constants for the 1-to-2 stream demux.
// Channel tags, FIFO depth and the default data width live here.
package demux1x2_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int FIFO_DEPTH = 2;
    localparam int OCC_W = 2;
    localparam int CNT_W = 8;

    typedef logic [OCC_W-1:0] occ_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic occ_full(input occ_t occ);
        return occ == occ_t'(FIFO_DEPTH);
    endfunction

    function automatic logic occ_empty(input occ_t occ);
        return occ == '0;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry per-channel FIFO; head word is registered storage.
// Push is ignored when full, pop is ignored when empty.
module demux_chan_fifo
    import demux1x2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output occ_t             occ
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    occ_t             occ_q;
    logic             do_push;
    logic             do_pop;

    assign full    = occ_full(occ_q);
    assign empty   = occ_empty(occ_q);
    assign occ     = occ_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // push+pop together leaves occupancy unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + occ_t'(1);
                2'b01:   occ_q <= occ_q - occ_t'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/demux1x2_stream.sv
// Routes each accepted word to channel A or B by in_sel.
// Each channel buffers in its own FIFO and counts accepted words.
module demux1x2_stream
    import demux1x2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [7:0]       a_cnt,
    output logic [7:0]       b_cnt
);

    logic a_full;
    logic b_full;
    logic a_empty;
    logic b_empty;
    logic a_push;
    logic b_push;
    logic accept;
    occ_t a_occ;
    occ_t b_occ;
    logic unused_occ;

    assign unused_occ = ^{a_occ, b_occ};

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (in_sel == CH_B) ? !b_full : !a_full;
        end
    end

    assign accept = in_valid && in_ready;
    assign a_push = accept && (in_sel == CH_A);
    assign b_push = accept && (in_sel == CH_B);

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;

    demux_chan_fifo #(.WIDTH(WIDTH)) u_chan_a (
        .clk   (clk),
        .rst   (rst),
        .push  (a_push),
        .pop   (a_ready),
        .din   (in_data),
        .dout  (a_data),
        .full  (a_full),
        .empty (a_empty),
        .occ   (a_occ)
    );

    demux_chan_fifo #(.WIDTH(WIDTH)) u_chan_b (
        .clk   (clk),
        .rst   (rst),
        .push  (b_push),
        .pop   (b_ready),
        .din   (in_data),
        .dout  (b_data),
        .full  (b_full),
        .empty (b_empty),
        .occ   (b_occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (a_push) a_cnt <= a_cnt + 8'd1;
            if (b_push) b_cnt <= b_cnt + 8'd1;
        end
    end

endmodule
